// File: rtl/clock_pkg.sv
// Shared types and limits for the time-entry controller: FSM states, field
// encoding, BCD digit limits and small decode helpers.
package clock_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHTens,
    StHOnes,
    StMTens,
    StMOnes
  } state_e;

  typedef enum logic [1:0] {
    FieldHt = 2'd0,
    FieldHo = 2'd1,
    FieldMt = 2'd2,
    FieldMo = 2'd3
  } field_e;

  localparam logic [3:0] HT_MAX       = 4'd2;
  localparam logic [3:0] HO_MAX_24    = 4'd3;
  localparam logic [3:0] HO_MAX       = 4'd9;
  localparam logic [3:0] MT_MAX       = 4'd5;
  localparam logic [3:0] MO_MAX       = 4'd9;
  localparam logic [3:0] PENDING_NONE = 4'hF;

  function automatic field_e state_field(state_e s);
    case (s)
      StHOnes: return FieldHo;
      StMTens: return FieldMt;
      StMOnes: return FieldMo;
      default: return FieldHt;
    endcase
  endfunction

  // Hours-ones is capped at 3 once the hours-tens digit is 2 (24-hour clock).
  function automatic logic [3:0] digit_max(field_e f, logic [3:0] ht);
    case (f)
      FieldHt: return HT_MAX;
      FieldHo: return (ht == HT_MAX) ? HO_MAX_24 : HO_MAX;
      FieldMt: return MT_MAX;
      default: return MO_MAX;
    endcase
  endfunction

  function automatic logic [3:0] onehot_index(logic [9:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int k = 0; k < 10; k++) begin
      if (v[k]) idx = 4'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Registered rising-edge detector: lvl_o is the sampled input, ev_o pulses for
// one cycle in the cycle after an input bit rises.
module key_edge_detect #(
  parameter int unsigned Width = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] din_i,
  output logic [Width-1:0] lvl_o,
  output logic [Width-1:0] ev_o
);

  logic [Width-1:0] lvl_q, ev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_q <= '0;
      ev_q  <= '0;
    end else begin
      lvl_q <= din_i;
      ev_q  <= din_i & ~lvl_q;
    end
  end

  assign lvl_o = lvl_q;
  assign ev_o  = ev_q;

endmodule

// File: rtl/time_entry_controller.sv
// HH:MM entry sequencer from keyboard-decoder levels into clock/alarm BCD registers.
// Optional ENTRY_TIMEOUT_EN abandons an entry after TIMEOUT_CYCLES idle cycles.
module time_entry_controller
  import clock_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  num,
  input  logic        enter,
  input  logic        c,
  input  logic        a,
  output logic        set_time,
  output logic [15:0] time_bcd,
  output logic [15:0] alarm_bcd,
  output logic        alarm_valid,
  output logic        busy,
  output logic [1:0]  field,
  output logic [3:0]  pending,
  output logic        err
);

  logic [12:0] key_lvl, key_ev;

  key_edge_detect #(
    .Width(13)
  ) u_key_edge (
    .clk  (clk),
    .reset(reset),
    .din_i({num, enter, c, a}),
    .lvl_o(key_lvl),
    .ev_o (key_ev)
  );

  logic [9:0] num_lvl;
  logic       num_ev, enter_ev, c_ev, a_ev;
  assign num_lvl  = key_lvl[12:3];
  assign num_ev   = |key_ev[12:3];
  assign enter_ev = key_ev[2];
  assign c_ev     = key_ev[1];
  assign a_ev     = key_ev[0];

  logic unused_lvl;
  assign unused_lvl = ^key_lvl[2:0];

  state_e      state_q, state_d;
  logic        alarm_mode_q, alarm_mode_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  pending_q, pending_d;
  logic        set_time_q, set_time_d;
  logic [15:0] time_bcd_q, time_bcd_d;
  logic [15:0] alarm_bcd_q, alarm_bcd_d;
  logic        alarm_valid_q, alarm_valid_d;
  logic        err_q, err_d;

  field_e     cur_field;
  logic [3:0] digit;
  logic       timeout;
  assign cur_field = state_field(state_q);
  assign digit     = onehot_index(num_lvl);

`ifdef ENTRY_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  logic            any_ev;
  logic [CntW-1:0] cnt_q;
  assign any_ev = |key_ev;

  // Cleared by any event, so restarts and field advances also rearm it.
  always_ff @(posedge clk) begin
    if (reset || any_ev || (state_q == StIdle)) begin
      cnt_q <= '0;
    end else if (cnt_q != CntMax) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout = (state_q != StIdle) && !any_ev && (cnt_q == CntMax);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    alarm_mode_d  = alarm_mode_q;
    shadow_d      = shadow_q;
    pending_d     = pending_q;
    set_time_d    = 1'b0;
    time_bcd_d    = time_bcd_q;
    alarm_bcd_d   = alarm_bcd_q;
    alarm_valid_d = alarm_valid_q;
    err_d         = 1'b0;

    // Mode keys win everywhere, idle or mid-entry; lower events that cycle are dropped.
    if (c_ev || a_ev) begin
      state_d      = StHTens;
      alarm_mode_d = c_ev;
      shadow_d     = '0;
      pending_d    = PENDING_NONE;
    end else if (state_q != StIdle) begin
      if (enter_ev) begin
        if (pending_q == PENDING_NONE) begin
          err_d = 1'b1;
        end else begin
          pending_d = PENDING_NONE;
          unique case (cur_field)
            FieldHt: begin shadow_d[15:12] = pending_q; state_d = StHOnes; end
            FieldHo: begin shadow_d[11:8]  = pending_q; state_d = StMTens; end
            FieldMt: begin shadow_d[7:4]   = pending_q; state_d = StMOnes; end
            FieldMo: begin shadow_d[3:0]   = pending_q; state_d = StIdle;  end
          endcase
          if (cur_field == FieldMo) begin
            if (alarm_mode_q) begin
              alarm_bcd_d   = shadow_d;
              alarm_valid_d = 1'b1;
            end else begin
              set_time_d = 1'b1;
              time_bcd_d = shadow_d;
            end
          end
        end
      end else if (num_ev) begin
        if (!$onehot(num_lvl) || (digit > digit_max(cur_field, shadow_q[15:12]))) begin
          err_d = 1'b1;
        end else begin
          pending_d = digit;
        end
      end else if (timeout) begin
        state_d   = StIdle;
        err_d     = 1'b1;
        shadow_d  = '0;
        pending_d = PENDING_NONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      alarm_mode_q  <= 1'b0;
      shadow_q      <= '0;
      pending_q     <= PENDING_NONE;
      set_time_q    <= 1'b0;
      time_bcd_q    <= '0;
      alarm_bcd_q   <= '0;
      alarm_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      alarm_mode_q  <= alarm_mode_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      set_time_q    <= set_time_d;
      time_bcd_q    <= time_bcd_d;
      alarm_bcd_q   <= alarm_bcd_d;
      alarm_valid_q <= alarm_valid_d;
      err_q         <= err_d;
    end
  end

  assign set_time    = set_time_q;
  assign time_bcd    = time_bcd_q;
  assign alarm_bcd   = alarm_bcd_q;
  assign alarm_valid = alarm_valid_q;
  assign busy        = (state_q != StIdle);
  assign field       = cur_field;
  assign pending     = pending_q;
  assign err         = err_q;

endmodule

// File: tb/tb_time_entry_controller.sv
// Self-checking bench for time_entry_controller: directed scenarios plus random
// key traffic, compared every cycle against a field/digit-level behavioural model.
module tb_time_entry_controller;

  localparam int unsigned TO = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  num = '0;
  logic        enter = 1'b0, c = 1'b0, a = 1'b0;
  logic        set_time, alarm_valid, busy, err;
  logic [15:0] time_bcd, alarm_bcd;
  logic [1:0]  field;
  logic [3:0]  pending;

  always #5 clk = ~clk;

  time_entry_controller #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .num        (num),
    .enter      (enter),
    .c          (c),
    .a          (a),
    .set_time   (set_time),
    .time_bcd   (time_bcd),
    .alarm_bcd  (alarm_bcd),
    .alarm_valid(alarm_valid),
    .busy       (busy),
    .field      (field),
    .pending    (pending),
    .err        (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: decoder events are seen one cycle after the input rises.
  logic [12:0] m_lvl, m_ev;
  bit          model_ready = 0;
  bit          m_busy, m_alarm_mode, m_set_time, m_err, m_alarm_valid;
  int          m_field, m_pending, idle;
  int          dig[4];
  logic [15:0] m_time, m_alarm;

  task model_reset();
    m_lvl = '0; m_ev = '0;
    m_busy = 0; m_alarm_mode = 0; m_set_time = 0; m_err = 0; m_alarm_valid = 0;
    m_field = 0; m_pending = 15; idle = 0;
    dig = '{default: 0};
    m_time = '0; m_alarm = '0;
  endtask

  task model_step(input logic [12:0] lvl, input logic [12:0] ev);
    int          d, lim;
    logic [15:0] val;
    m_set_time = 0;
    m_err = 0;
    if (|ev) idle = 0;
    if (ev[1] || ev[0]) begin
      m_busy = 1; m_alarm_mode = ev[1]; m_field = 0; m_pending = 15;
      dig = '{default: 0};
    end else if (m_busy) begin
      if (ev[2]) begin
        if (m_pending == 15) m_err = 1;
        else begin
          dig[m_field] = m_pending;
          m_pending = 15;
          if (m_field == 3) begin
            val = 16'(dig[0] * 4096 + dig[1] * 256 + dig[2] * 16 + dig[3]);
            if (m_alarm_mode) begin m_alarm = val; m_alarm_valid = 1; end
            else begin m_time = val; m_set_time = 1; end
            m_busy = 0; m_field = 0;
          end else m_field++;
        end
      end else if (|ev[12:3]) begin
        if ($countones(lvl[12:3]) != 1) m_err = 1;
        else begin
          d = 0;
          for (int k = 0; k < 10; k++) if (lvl[3+k]) d = k;
          case (m_field)
            0: lim = 2;
            1: lim = (dig[0] == 2) ? 3 : 9;
            2: lim = 5;
            default: lim = 9;
          endcase
          if (d > lim) m_err = 1;
          else m_pending = d;
        end
      end
`ifdef ENTRY_TIMEOUT_EN
      else begin
        idle++;
        if (idle >= TO) begin
          m_busy = 0; m_field = 0; m_pending = 15; m_err = 1;
        end
      end
`endif
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      model_reset();
      model_ready = 1;
    end else begin
      model_step(m_lvl, m_ev);
      m_ev  = {num, enter, c, a} & ~m_lvl;
      m_lvl = {num, enter, c, a};
    end
  end

  int st_high = 0;
  int err_high = 0;

  always @(negedge clk) begin
    if (model_ready) begin
      chk("set_time", 32'(set_time), 32'(m_set_time));
      chk("time_bcd", 32'(time_bcd), 32'(m_time));
      chk("alarm_bcd", 32'(alarm_bcd), 32'(m_alarm));
      chk("alarm_valid", 32'(alarm_valid), 32'(m_alarm_valid));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("field", 32'(field), 32'(m_field));
      chk("pending", 32'(pending), 32'(m_pending));
      chk("err", 32'(err), 32'(m_err));
      if (set_time === 1'b1) st_high++;
      if (err === 1'b1) err_high++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press_key(input int k);
    num = '0;
    num[k] = 1'b1;
    tick(2);
    num = '0;
    tick(2);
  endtask

  // sel: 0 = a (set time), 1 = c (set alarm), 2 = enter
  task automatic strobe(input int sel);
    if (sel == 0) a = 1'b1; else if (sel == 1) c = 1'b1; else enter = 1'b1;
    tick(2);
    a = 1'b0; c = 1'b0; enter = 1'b0;
    tick(2);
  endtask

  task automatic key_enter(input int k);
    press_key(k);
    strobe(2);
  endtask

  int st0, e0, r, r2;

  initial begin
    tick(3);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset pending", 32'(pending), 32'hF);
    chk("reset alarm_valid", 32'(alarm_valid), 32'd0);
    reset = 1'b0;
    tick(2);

    // Time entry 12:34
    st0 = st_high;
    strobe(0);
    key_enter(1); key_enter(2); key_enter(3); key_enter(4);
    tick(2);
    chk("time commit value", 32'(time_bcd), 32'h1234);
    chk("set_time one cycle", 32'(st_high - st0), 32'd1);
    chk("no alarm after time", 32'(alarm_valid), 32'd0);
    chk("idle after commit", 32'(busy), 32'd0);

    // Alarm entry with a rejected hours digit
    strobe(1);
    key_enter(2);
    e0 = err_high;
    press_key(4);
    chk("ho limit err", 32'(err_high - e0), 32'd1);
    chk("ho limit pending", 32'(pending), 32'hF);
    key_enter(3); key_enter(5); key_enter(9);
    tick(2);
    chk("alarm commit value", 32'(alarm_bcd), 32'h2359);
    chk("alarm_valid set", 32'(alarm_valid), 32'd1);

    // Held key gives a single event; two-hot is rejected
    strobe(0);
    key_enter(1);
    e0 = err_high;
    num = '0; num[7] = 1'b1;
    tick(100);
    chk("held key pending", 32'(pending), 32'd7);
    chk("held key no err", 32'(err_high - e0), 32'd0);
    num = '0;
    tick(2);
    num = 10'b0000000011;
    tick(2);
    num = '0;
    tick(2);
    chk("two-hot err", 32'(err_high - e0), 32'd1);
    chk("two-hot pending kept", 32'(pending), 32'd7);

    // c and enter together mid-entry: restart in alarm mode
    strobe(2);
    chk("advanced to Mt", 32'(field), 32'd2);
    c = 1'b1; enter = 1'b1;
    tick(2);
    c = 1'b0; enter = 1'b0;
    tick(2);
    chk("restart field", 32'(field), 32'd0);
    chk("restart pending", 32'(pending), 32'hF);
    chk("restart busy", 32'(busy), 32'd1);
    chk("restart time kept", 32'(time_bcd), 32'h1234);

    // Reset at Mo with staged digit
    key_enter(1); key_enter(2); key_enter(3);
    press_key(4);
    chk("staged field", 32'(field), 32'd3);
    chk("staged pending", 32'(pending), 32'd4);
    reset = 1'b1;
    tick(1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst alarm_bcd", 32'(alarm_bcd), 32'd0);
    chk("rst alarm_valid", 32'(alarm_valid), 32'd0);
    chk("rst time_bcd", 32'(time_bcd), 32'd0);
    chk("rst pending", 32'(pending), 32'hF);
    chk("rst field", 32'(field), 32'd0);
    reset = 1'b0;
    tick(2);

    // Random traffic
    for (int i = 0; i < 700; i++) begin
      r = int'($urandom_range(0, 99));
      c = (r < 3);
      a = (r >= 3 && r < 8);
      enter = ($urandom_range(0, 3) == 0);
      r2 = int'($urandom_range(0, 99));
      num = '0;
      if (r2 >= 35 && r2 < 65) num[$urandom_range(0, 5)] = 1'b1;
      else if (r2 >= 65 && r2 < 90) num[$urandom_range(0, 9)] = 1'b1;
      else if (r2 >= 90) num = 10'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      tick(int'($urandom_range(1, 4)));
      if ($urandom_range(0, 49) == 0) begin
        c = 1'b0; a = 1'b0; enter = 1'b0; num = '0; reset = 1'b0;
        tick(25);
      end
    end
    c = 1'b0; a = 1'b0; enter = 1'b0; num = '0; reset = 1'b0;
    tick(3);

`ifdef ENTRY_TIMEOUT_EN
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    e0 = err_high;
    st0 = st_high;
    strobe(0);
    press_key(1);
    tick(25);
    chk("timeout busy", 32'(busy), 32'd0);
    chk("timeout err pulse", 32'(err_high - e0), 32'd1);
    chk("timeout no set_time", 32'(st_high - st0), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/time_entry_controller.md
# time_entry_controller

Sequences user time entry from the keyboard decoder's strobes into BCD clock-time and alarm registers. Edge-detects the decoder's level outputs (digit one-hot, enter, set-alarm, set-time) and runs a field-by-field FSM (HH:MM). Validates each digit against clock limits and commits the completed value either as a one-cycle `set_time` load toward the timekeeping counter, or into the held alarm register consumed by the alarm comparator.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 50_000_000 — idle cycles before an unfinished entry is abandoned; only used with `ENTRY_TIMEOUT_EN`.

Ports:
- `clk`  in  1  — system clock, single domain.
- `reset`  in  1  — synchronous, active-high.
- `num`  in  10  — decoder digit levels; bit k = key k held.
- `enter`  in  1  — decoder "next field / commit" level.
- `c`  in  1  — decoder "set alarm" level; starts alarm entry.
- `a`  in  1  — decoder "set time" level; starts clock-time entry.
- `set_time`  out  1  — one-cycle load strobe for the timekeeping counter.
- `time_bcd`  out  16  — {Ht, Ho, Mt, Mo} BCD; valid while `set_time`=1, holds otherwise.
- `alarm_bcd`  out  16  — committed alarm {Ht, Ho, Mt, Mo}; holds.
- `alarm_valid`  out  1  — set on first alarm commit; cleared only by reset.
- `busy`  out  1  — high in any state other than IDLE.
- `field`  out  2  — current field: 0=Ht, 1=Ho, 2=Mt, 3=Mo.
- `pending`  out  4  — digit staged in the current field; 4'hF = none.
- `err`  out  1  — one-cycle pulse on a rejected key or a timeout.

## Operation
- Each input is registered (`*_q`); an event is `x & ~x_q`. Held keys produce exactly one event.
- A digit event requires `num` to be exactly one-hot. Zero or multiple bits high on a rising edge → `err`, no state change.
- FSM states: IDLE, H_TENS, H_ONES, M_TENS, M_ONES.
  - IDLE: a `c` event → H_TENS in alarm mode; an `a` event → H_TENS in time mode. `enter` and digits are ignored without `err`.
  - In a field state:
    - A valid digit overwrites `pending`.
    - `enter` with `pending`≠F stores the digit into the shadow register, clears `pending`, and advances.
    - `enter` with `pending`=F → `err`, no move.
  - M_ONES + valid `enter` → commit, then IDLE.
    - Time mode: `set_time`=1 for one cycle, `time_bcd` = shadow.
    - Alarm mode: `alarm_bcd` ← shadow, `alarm_valid` ← 1.
- Digit limits:
  - Ht: 0–2.
  - Ho: 0–9, or 0–3 if the stored Ht = 2.
  - Mt: 0–5.
  - Mo: 0–9.
  - An out-of-range digit → `err`; `pending` is unchanged.
- A `c` or `a` event while busy restarts at H_TENS in the new mode; shadow and `pending` are discarded, no `err`.
- Simultaneous events in the same cycle, priority: `c` > `a` > `enter` > digit. Lower-priority events that cycle are dropped silently.
- A committed alarm is never altered by an aborted entry.

## Timing
- Reset values:
  - `set_time`=0, `time_bcd`=0, `alarm_bcd`=0, `alarm_valid`=0, `busy`=0, `field`=0, `pending`=F, `err`=0.
  - State = IDLE, shadow = 0, `*_q` = 0.
- An input rising in cycle n is an event in cycle n+1 (`_q` register). The state, `pending`, `err`, and commit outputs update at the end of cycle n+1.
- All outputs are registered; `set_time` and `err` are exactly one cycle wide.
- Reset mid-entry aborts immediately; no commit. A key held across reset release produces an event one cycle later.

## Configuration
- `ENTRY_TIMEOUT_EN` defined:
  - A counter clears on every event and on entering a field state.
  - While busy, when the count reaches `TIMEOUT_CYCLES-1` → IDLE, `err` pulse, shadow discarded.
- Not defined: no counter; an entry waits indefinitely, and `TIMEOUT_CYCLES` is unused.

## Structure
- `clock_pkg`:
  - FSM state enum and field encoding.
  - BCD limit constants (`HT_MAX`=2, `HO_MAX_24`=3, `MT_MAX`=5).
  - `PENDING_NONE`=4'hF.
- Sub-module `key_edge_detect`: parameterised width, registered edge detect, instantiated once for {`num`, `enter`, `c`, `a`} (13 bits).

## Test plan
- `a` pulse; keys 1,enter,2,enter,3,enter,4,enter → `set_time` one cycle, `time_bcd`=16'h1234, `alarm_valid`=0.
- `c`; 2,enter,4 → `err`, `pending` stays F; 3,enter,5,enter,9,enter → `alarm_bcd`=16'h2359, `alarm_valid`=1.
- Hold key 7 for 100 cycles in H_ONES → exactly one digit event; `num`=10'b0000000011 → `err`, `pending` unchanged.
- Time mode mid-entry (`field`=2), `c` and `enter` rise together → alarm mode, `field`=0, `pending`=F, `time_bcd` unchanged.
- Reset asserted at `field`=3 with a staged digit → all outputs at reset values next cycle; `alarm_bcd` cleared.
- With `ENTRY_TIMEOUT_EN` and `TIMEOUT_CYCLES`=20: `a`, key 1, then idle 20 cycles → `busy`=0, one `err` pulse, no `set_time`.
